// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 5;
    localparam int unsigned NUM_READ_DEF  = 2;
    localparam int unsigned NUM_WRITE_DEF = 2;
    localparam int unsigned ZERO_IDX      = 0;

    // Widest packed bus and widest single field the helper must handle
    localparam int unsigned MAX_BUS_W   = 128;
    localparam int unsigned MAX_SLICE_W = 32;

    function automatic logic [MAX_SLICE_W-1:0] bus_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        return MAX_SLICE_W'(bus >> (idx * width));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bus of the register file; the pipeline is master.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0]  ReadRegister;
    logic [NUM_READ*DATA_WIDTH-1:0]  ReadData;
    logic [NUM_READ-1:0]             ReadPending;
    logic [NUM_WRITE-1:0]            RegWrite;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] WriteRegister;
    logic [NUM_WRITE*DATA_WIDTH-1:0] WriteData;
    logic                            Reserve;
    logic [ADDR_WIDTH-1:0]           ReserveRegister;

    modport master (
        output ReadRegister, RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister,
        input  ReadData, ReadPending
    );

    modport slave (
        input  ReadRegister, RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister,
        output ReadData, ReadPending
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on reserve, cleared on writeback, reserve wins.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            set_i,
    input  logic [ADDR_WIDTH-1:0]           set_addr_i,
    input  logic [NUM_WRITE-1:0]            clr_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_READ-1:0]             pend_c_o
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Clears first so a same-cycle reserve (newer producer) overrides them
    always_comb begin
        pend_d = pend_q;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (clr_i[j]) begin
                pend_d[clr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (set_i) begin
            pend_d[set_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_c_o = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            pend_c_o[i] = pend_q[rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register, write bypass and pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned NUM_READ   = NUM_READ_DEF,
    parameter int unsigned NUM_WRITE  = NUM_WRITE_DEF,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
    logic [ADDR_WIDTH-1:0] wr_addr [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wr_data [NUM_WRITE];
    logic [NUM_WRITE-1:0]  wr_en;
    logic [DATA_WIDTH-1:0] regs_q  [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d  [DEPTH];
    logic [NUM_READ-1:0]   sb_pend;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  byp_hit;

    // Unpack the port buses; writes to a hardwired zero register are dropped here
    always_comb begin
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            rd_addr[i] = ADDR_WIDTH'(bus_slice(MAX_BUS_W'(bus.ReadRegister), i, ADDR_WIDTH));
        end
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            wr_addr[j] = ADDR_WIDTH'(bus_slice(MAX_BUS_W'(bus.WriteRegister), j, ADDR_WIDTH));
            wr_data[j] = DATA_WIDTH'(bus_slice(MAX_BUS_W'(bus.WriteData), j, DATA_WIDTH));
            wr_en[j]   = bus.RegWrite[j] &&
                         !((ZERO_REG != 0) && (wr_addr[j] == ADDR_WIDTH'(ZERO_IDX)));
        end
    end

    // Ascending port order: the highest-numbered port wins an address conflict
    always_comb begin
        regs_d = regs_q;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (wr_en[j]) begin
                regs_d[wr_addr[j]] = wr_data[j];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .NUM_WRITE  (NUM_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .set_i      (bus.Reserve),
        .set_addr_i (bus.ReserveRegister),
        .clr_i      (wr_en),
        .clr_addr_i (bus.WriteRegister),
        .rd_addr_i  (bus.ReadRegister),
        .pend_c_o   (sb_pend)
    );

    // Read muxes; bypass is held off in reset so outputs stay zero
    always_comb begin
        bus.ReadData    = '0;
        bus.ReadPending = '0;
        rd_val          = '0;
        byp_hit         = 1'b0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            rd_val  = regs_q[rd_addr[i]];
            byp_hit = 1'b0;
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                    if (Reset_n && wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
                        rd_val  = wr_data[j];
                        byp_hit = 1'b1;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[i] == ADDR_WIDTH'(ZERO_IDX))) begin
                rd_val = '0;
            end
            bus.ReadData[i*DATA_WIDTH +: DATA_WIDTH] = rd_val;
            bus.ReadPending[i] = sb_pend[i] && !byp_hit;
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 32-bit datapath: N combinational read ports, M clocked write ports, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard that lets the pipeline reserve a destination at issue and clear it at writeback. It replaces the fixed 32x32 two-read/one-write register file in the decode stage and feeds the hazard unit through `ReadPending`.

## Interface
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: address width. Depth is 2^ADDR_WIDTH.
- `NUM_READ`, 2: number of read ports, 1..4.
- `NUM_WRITE`, 2: number of write ports, 1..2.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and is never written or reserved.
- `BYPASS`, 1: when 1, same-cycle write data forwards to matching read ports.
- `Clk`  in  1  clock, all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ReadRegister`  in  NUM_READ*ADDR_WIDTH  read addresses. Port i is at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `ReadData`  out  NUM_READ*DATA_WIDTH  read data, packed the same way.
- `ReadPending`  out  NUM_READ  pending flag of the addressed register.
- `RegWrite`  in  NUM_WRITE  per-port write enable.
- `WriteRegister`  in  NUM_WRITE*ADDR_WIDTH  write addresses.
- `WriteData`  in  NUM_WRITE*DATA_WIDTH  write data.
- `Reserve`  in  1  set the pending bit of `ReserveRegister`.
- `ReserveRegister`  in  ADDR_WIDTH  register to reserve.
- The clock is `Clk`. Reset is asynchronous and active-low on `Reset_n`. There is one clock domain.

## Operation
- **Reset.** While `Reset_n`=0, every register is 0 and every pending bit is 0, immediately and without waiting for a clock edge. Consequently `ReadData`=0 and `ReadPending`=0 during reset.
- **Write.** On a rising edge, each port j with `RegWrite[j]`=1 stores its `WriteData` into its `WriteRegister`.
- **Write conflict.** If both write ports target the same address, port 1 wins. No error is flagged.
- **Read.** `ReadData` is combinational from the array.
- **Bypass (BYPASS=1).** If a write port with `RegWrite`=1 matches a read address, `ReadData` shows that port's `WriteData` in the same cycle. When both write ports match, port 1's data is shown.
- **Bypass (BYPASS=0).** Read data shows the old contents until after the edge.
- **Register 0 (ZERO_REG=1).** Writes to register 0 are discarded. Reads of register 0 return 0, including under bypass. `Reserve` of register 0 is ignored, and `ReadPending` for register 0 is always 0.
- **Scoreboard set.** A rising edge with `Reserve`=1 sets `pend[ReserveRegister]`.
- **Scoreboard clear.** A write with `RegWrite[j]`=1 clears `pend[WriteRegister[j]]`.
- **Reserve and write together.** If both hit the same register in one cycle, the reserve wins: the bit stays 1, because it represents a newer producer. The write data is still stored.
- **Pending output.** `ReadPending[i]` = `pend[ReadRegister[i]]`, except when BYPASS=1 and an active write matches that read address, in which case it is 0.
- **Flag semantics.** Pending is advisory only. Writes are never blocked.

## Timing
- Read latency: 0 cycles, combinational from the address.
- Write latency: visible on reads 1 edge later. With BYPASS=1 it is also visible in the same cycle.
- Reserve latency: pending is visible after 1 edge.
- **Reset mid-operation.** Asserting `Reset_n` during a write cycle aborts the write. After `Reset_n` rises, the first edge performs normal writes.
- There is no stall or back-pressure. Every port accepts a request on every cycle.

## Structure
- **Package `regfile_pkg`.** Holds the default width and depth constants, the register-0 index, and a function that extracts slice i of a packed bus.
- **Sub-module `regfile_scoreboard`.** A depth-bit pending vector with set/clear priority logic and per-port lookup.
- **Inside `regfile_mp` itself:**
  - the data array;
  - the write-conflict priority;
  - the per-port read muxes with bypass.

## Test plan
1. **Reset.** Write 32'hABCDEF98 to reg 8, then pulse `Reset_n` low for 3 ns between edges. Required: reg 8 reads 0 immediately, and `ReadPending` is 0.
2. **Zero register.** With ZERO_REG=1, write 32'hABCDEF98 to reg 0 and reserve reg 0. Required: both read ports at reg 0 give 0 with pending 0. With ZERO_REG=0, the same stimulus reads back 32'hABCDEF98.
3. **Bulk write and read.** Write regs 8..25 with distinct values (reg 8 = 32'h0ECE274A, reg 25 = 32'h2F1EFFFF), two per cycle on both write ports. Then read them in pairs. Required: every value matches.
4. **Write conflict and bypass.**
   - Stimulus: port 0 writes 32'h1111 and port 1 writes 32'h2222 to reg 21 in the same cycle, with read port 0 at reg 21.
   - Required in that cycle: BYPASS=1 reads 32'h2222, and BYPASS=0 reads the old value.
   - Required after the edge: reg 21 reads 32'h2222.
5. **Scoreboard.**
   - Reserve reg 31. Required: pending is 1 on the next cycle.
   - Then write 32'd1000 to reg 31. Required: pending is 0 in the same cycle with BYPASS=1, and 0 after the edge for both BYPASS settings.
   - Then reserve and write reg 31 in the same cycle. Required: pending stays 1 and reg 31 reads the new data.
6. **Parameter sweep.** DATA_WIDTH=16, ADDR_WIDTH=3, NUM_READ=4, NUM_WRITE=1. Write 16'hBEEF to reg 7 and read it on all four ports. Required: all four read 16'hBEEF.
